// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the unified-RAM data-port arbiter: owner and FSM state
// encodings, default bus widths and the latency counter width.
package ram_port_arbiter_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;
    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int CNT_W  = 3;

    typedef enum logic {
        OWN_BIOS = 1'b0,
        OWN_CORE = 1'b1
    } owner_e;

    typedef enum logic {
        IDLE  = 1'b0,
        RWAIT = 1'b1
    } arb_state_e;

    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_BIOS) ? OWN_CORE : OWN_BIOS;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the two requesters (BIOS, core), the arbiter and the
// RAM data port. slave = arbiter view, master = environment view.
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
);
    // BIOS requester
    logic              i_b_req;
    logic              i_b_we;
    logic [DW/8-1:0]   i_b_be;
    logic [AW-1:0]     i_b_addr;
    logic [DW-1:0]     i_b_wdata;
    logic              o_b_gnt;
    logic              o_b_rvalid;
    logic [DW-1:0]     o_b_rdata;
    // Core load/store requester
    logic              i_c_req;
    logic              i_c_we;
    logic [DW/8-1:0]   i_c_be;
    logic [AW-1:0]     i_c_addr;
    logic [DW-1:0]     i_c_wdata;
    logic              o_c_gnt;
    logic              o_c_rvalid;
    logic [DW-1:0]     o_c_rdata;
    // RAM data port
    logic              o_read_req;
    logic [AW-1:0]     o_read_addr;
    logic [DW-1:0]     i_read_data;
    logic              o_write_enable;
    logic [DW/8-1:0]   o_byte_enable;
    logic [AW-1:0]     o_write_addr;
    logic [DW-1:0]     o_write_data;
    logic              o_busy;

    modport slave (
        input  i_b_req, i_b_we, i_b_be, i_b_addr, i_b_wdata,
        output o_b_gnt, o_b_rvalid, o_b_rdata,
        input  i_c_req, i_c_we, i_c_be, i_c_addr, i_c_wdata,
        output o_c_gnt, o_c_rvalid, o_c_rdata,
        output o_read_req, o_read_addr,
        input  i_read_data,
        output o_write_enable, o_byte_enable, o_write_addr, o_write_data,
        output o_busy
    );

    modport master (
        output i_b_req, i_b_we, i_b_be, i_b_addr, i_b_wdata,
        input  o_b_gnt, o_b_rvalid, o_b_rdata,
        output i_c_req, i_c_we, i_c_be, i_c_addr, i_c_wdata,
        input  o_c_gnt, o_c_rvalid, o_c_rdata,
        input  o_read_req, o_read_addr,
        output i_read_data,
        input  o_write_enable, o_byte_enable, o_write_addr, o_write_data,
        input  o_busy
    );

endinterface

// File: rtl/ram_port_arbiter_rr2.sv
// Two-way round-robin pick between BIOS and core. mask_c removes the core
// from arbitration entirely (used while the BIOS still owns the port).
module ram_port_arbiter_rr2
    import ram_port_arbiter_pkg::*;
(
    input  logic   req_b,
    input  logic   req_c,
    input  logic   mask_c,
    input  owner_e ptr,
    output logic   valid,
    output owner_e winner
);

    logic c_ok;

    // Pick a single winner; on a tie the pointer decides.
    always_comb begin
        c_ok   = req_c & ~mask_c;
        valid  = req_b | c_ok;
        winner = OWN_BIOS;
        if (req_b && c_ok) begin
            winner = ptr;
        end else if (c_ok) begin
            winner = OWN_CORE;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the unified RAM data port between the BIOS loader and the core
// load/store unit. Writes complete in the grant cycle; reads park the FSM in
// RWAIT for RD_LAT cycles and return data to the requester that issued them.
// RD_LAT must lie in 1..7.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW     = MEM_AW,
    parameter int DW     = MEM_DW,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              i_booted,
    ram_port_arbiter_if.slave bus
);

    localparam int BW = DW / 8;

    typedef struct packed {
        logic          we;
        logic [BW-1:0] be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_req_t;

    arb_state_e       state;
    owner_e           owner;
    owner_e           rr_ptr;
    owner_e           winner;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    b_rdata_q;
    logic [DW-1:0]    c_rdata_q;
    logic             run;
    logic             pick_valid;
    logic             grant;
    logic             rd_done;
    mem_req_t         b_req_s;
    mem_req_t         c_req_s;
    mem_req_t         win_req;

    // Nothing may be granted or returned while frozen or held in reset.
    assign run = clk_en & rst_n;

    assign b_req_s = {bus.i_b_we, bus.i_b_be, bus.i_b_addr, bus.i_b_wdata};
    assign c_req_s = {bus.i_c_we, bus.i_c_be, bus.i_c_addr, bus.i_c_wdata};

    ram_port_arbiter_rr2 u_rr2 (
        .req_b  (bus.i_b_req),
        .req_c  (bus.i_c_req),
        .mask_c (~i_booted),
        .ptr    (rr_ptr),
        .valid  (pick_valid),
        .winner (winner)
    );

    assign grant   = run & (state == IDLE) & pick_valid;
    assign win_req = (winner == OWN_CORE) ? c_req_s : b_req_s;

    // Same-cycle grant and RAM strobes driven from the winning request.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        bus.o_b_gnt        = 1'b0;
        bus.o_c_gnt        = 1'b0;
        bus.o_read_req     = 1'b0;
        bus.o_read_addr    = '0;
        bus.o_write_enable = 1'b0;
        bus.o_byte_enable  = '0;
        bus.o_write_addr   = '0;
        bus.o_write_data   = '0;
        if (grant) begin
            bus.o_b_gnt = (winner == OWN_BIOS);
            bus.o_c_gnt = (winner == OWN_CORE);
            if (win_req.we) begin
                bus.o_write_enable = 1'b1;
                bus.o_byte_enable  = win_req.be;
                bus.o_write_addr   = win_req.addr;
                bus.o_write_data   = win_req.wdata;
            end else begin
                bus.o_read_req  = 1'b1;
                bus.o_read_addr = win_req.addr;
            end
        end
    end

    // Read return: the pulse coincides with valid RAM data, which is
    // forwarded straight through while the owner's register captures it.
    assign rd_done        = run & (state == RWAIT) & (cnt == '0);
    assign bus.o_b_rvalid = rd_done & (owner == OWN_BIOS);
    assign bus.o_c_rvalid = rd_done & (owner == OWN_CORE);
    assign bus.o_b_rdata  = bus.o_b_rvalid ? bus.i_read_data : b_rdata_q;
    assign bus.o_c_rdata  = bus.o_c_rvalid ? bus.i_read_data : c_rdata_q;
    assign bus.o_busy     = (state == RWAIT);

    // Arbitration FSM with latency counter, owner, rr pointer and rdata registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_BIOS;
            rr_ptr    <= OWN_BIOS;
            cnt       <= '0;
            // NOTE: the rdata registers are visible outputs, so they are reset too.
            b_rdata_q <= '0;
            c_rdata_q <= '0;
        end else if (clk_en) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (grant) begin
                        if (i_booted) begin
                            rr_ptr <= other_owner(winner);
                        end
                        if (!win_req.we) begin
                            owner <= winner;
                            cnt   <= CNT_W'(RD_LAT - 1);
                            state <= RWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (cnt == '0) begin
                        if (owner == OWN_BIOS) begin
                            b_rdata_q <= bus.i_read_data;
                        end else begin
                            c_rdata_q <= bus.i_read_data;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: one instance with RD_LAT=1 and one
// with RD_LAT=3, each fronted by a small latency-accurate RAM model.
module tb_ram_port_arbiter;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_en = 1'b1;
    logic booted = 1'b0;

    int vectors     = 0;
    int miscompares = 0;
    int writes1     = 0;

    ram_port_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    ram_port_arbiter_if #(.AW(32), .DW(32)) bus3 ();

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .i_booted (booted),
        .bus      (bus1)
    );

    ram_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .i_booted (booted),
        .bus      (bus3)
    );

    always #5 clk = ~clk;

    // RAM contents: 0x200 holds 0x12345678, every other word is {addr[15:0], 16'h5AA5}.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a == 32'h200) ? 32'h1234_5678 : {a[15:0], 16'h5AA5};
    endfunction

    // RD_LAT=1 RAM: data valid the cycle after the read strobe, garbage otherwise.
    logic [31:0] ram1_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram1_q <= '0;
        else if (clk_en) ram1_q <= bus1.o_read_req ? ram_word(bus1.o_read_addr) : 32'hBAD0_BAD0;
    end
    assign bus1.i_read_data = ram1_q;

    // RD_LAT=3 RAM: three-stage pipeline, frozen along with clk_en.
    logic [31:0] ram3_q [3];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram3_q[0] <= '0;
            ram3_q[1] <= '0;
            ram3_q[2] <= '0;
        end else if (clk_en) begin
            ram3_q[0] <= bus3.o_read_req ? ram_word(bus3.o_read_addr) : 32'hBAD0_BAD0;
            ram3_q[1] <= ram3_q[0];
            ram3_q[2] <= ram3_q[1];
        end
    end
    assign bus3.i_read_data = ram3_q[2];

    // Counts RAM writes actually committed by the RD_LAT=1 instance.
    always @(posedge clk) begin
        if (clk_en && bus1.o_write_enable) writes1 <= writes1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic drive1(input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                          input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd);
        bus1.i_b_req = br; bus1.i_b_we = bw; bus1.i_b_be = bw ? 4'hF : 4'h0;
        bus1.i_b_addr = ba; bus1.i_b_wdata = bd;
        bus1.i_c_req = cr; bus1.i_c_we = cw; bus1.i_c_be = cw ? 4'hF : 4'h0;
        bus1.i_c_addr = ca; bus1.i_c_wdata = cd;
    endtask

    task automatic drive3(input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                          input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd);
        bus3.i_b_req = br; bus3.i_b_we = bw; bus3.i_b_be = bw ? 4'hF : 4'h0;
        bus3.i_b_addr = ba; bus3.i_b_wdata = bd;
        bus3.i_c_req = cr; bus3.i_c_we = cw; bus3.i_c_be = cw ? 4'hF : 4'h0;
        bus3.i_c_addr = ca; bus3.i_c_wdata = cd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---- Reset: requests present but everything held at 0 ----
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("rst_b_gnt", bus1.o_b_gnt, 1'b0);
        check_bit("rst_read_req", bus1.o_read_req, 1'b0);
        check_bit("rst_busy", bus1.o_busy, 1'b0);
        check("rst_b_rdata", bus1.o_b_rdata, 32'h0);
        check_bit("rst_c_rvalid", bus1.o_c_rvalid, 1'b0);

        // ---- 1: booted=0, BIOS write while the core also requests ----
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h300, 32'h0);
        #1;
        check_bit("t1_b_gnt", bus1.o_b_gnt, 1'b1);
        check_bit("t1_c_gnt", bus1.o_c_gnt, 1'b0);
        check_bit("t1_we", bus1.o_write_enable, 1'b1);
        check("t1_waddr", bus1.o_write_addr, 32'h100);
        check("t1_wdata", bus1.o_write_data, 32'hDEAD_BEEF);
        check("t1_be", {28'h0, bus1.o_byte_enable}, 32'hF);
        check_bit("t1_rd", bus1.o_read_req, 1'b0);
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
        #1;
        check_bit("t1_c_gnt_masked", bus1.o_c_gnt, 1'b0);
        check_bit("t1_rd_masked", bus1.o_read_req, 1'b0);

        // ---- 2: booted=1, both read every cycle, RD_LAT=1 ----
        @(negedge clk);
        booted = 1'b1;
        drive1(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        check("t1_write_count", 32'(writes1), 32'd1);
        check_bit("t2_c0_b_gnt", bus1.o_b_gnt, 1'b1);
        check_bit("t2_c0_c_gnt", bus1.o_c_gnt, 1'b0);
        check("t2_c0_raddr", bus1.o_read_addr, 32'h10);
        @(negedge clk); #1;
        check_bit("t2_c1_b_rvalid", bus1.o_b_rvalid, 1'b1);
        check("t2_c1_b_rdata", bus1.o_b_rdata, 32'h0010_5AA5);
        check_bit("t2_c1_c_rvalid", bus1.o_c_rvalid, 1'b0);
        check_bit("t2_c1_no_gnt", bus1.o_b_gnt | bus1.o_c_gnt, 1'b0);
        @(negedge clk); #1;
        check_bit("t2_c2_c_gnt", bus1.o_c_gnt, 1'b1);
        check_bit("t2_c2_b_gnt", bus1.o_b_gnt, 1'b0);
        check("t2_c2_raddr", bus1.o_read_addr, 32'h20);
        @(negedge clk); #1;
        check_bit("t2_c3_c_rvalid", bus1.o_c_rvalid, 1'b1);
        check("t2_c3_c_rdata", bus1.o_c_rdata, 32'h0020_5AA5);
        check_bit("t2_c3_b_rvalid", bus1.o_b_rvalid, 1'b0);
        @(negedge clk); #1;
        check_bit("t2_c4_b_gnt", bus1.o_b_gnt, 1'b1);
        check_bit("t2_c4_c_gnt", bus1.o_c_gnt, 1'b0);
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("t2_c5_b_rvalid", bus1.o_b_rvalid, 1'b1);
        check("t2_c5_b_rdata", bus1.o_b_rdata, 32'h0010_5AA5);
        @(negedge clk); #1;
        check_bit("t2_c6_b_rvalid", bus1.o_b_rvalid, 1'b0);
        check("t2_c6_b_hold", bus1.o_b_rdata, 32'h0010_5AA5);
        check("t2_c6_c_hold", bus1.o_c_rdata, 32'h0020_5AA5);
        check_bit("t2_c6_busy", bus1.o_busy, 1'b0);

        // ---- 4: core read outstanding, then booted drops ----
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0);
        #1;
        check_bit("t4_c0_c_gnt", bus1.o_c_gnt, 1'b1);
        check("t4_c0_raddr", bus1.o_read_addr, 32'h30);
        @(negedge clk);
        booted = 1'b0;
        drive1(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        #1;
        check_bit("t4_c1_c_rvalid", bus1.o_c_rvalid, 1'b1);
        check("t4_c1_c_rdata", bus1.o_c_rdata, 32'h0030_5AA5);
        check_bit("t4_c1_b_rvalid", bus1.o_b_rvalid, 1'b0);
        check_bit("t4_c1_b_gnt", bus1.o_b_gnt, 1'b0);
        @(negedge clk); #1;
        check_bit("t4_c2_b_gnt", bus1.o_b_gnt, 1'b1);
        check_bit("t4_c2_c_gnt", bus1.o_c_gnt, 1'b0);
        check("t4_c2_raddr", bus1.o_read_addr, 32'h50);
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h34, 32'h0);
        #1;
        check_bit("t4_c3_b_rvalid", bus1.o_b_rvalid, 1'b1);
        check("t4_c3_b_rdata", bus1.o_b_rdata, 32'h0050_5AA5);
        check_bit("t4_c3_c_rvalid", bus1.o_c_rvalid, 1'b0);
        @(negedge clk); #1;
        check_bit("t4_c4_c_gnt", bus1.o_c_gnt, 1'b0);
        check_bit("t4_c4_rd", bus1.o_read_req, 1'b0);

        // clk_en=0 in IDLE suppresses grants, then back-to-back writes
        @(negedge clk);
        clk_en = 1'b0;
        drive1(1'b1, 1'b1, 32'h60, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("ce_b_gnt", bus1.o_b_gnt, 1'b0);
        check_bit("ce_we", bus1.o_write_enable, 1'b0);
        @(negedge clk);
        clk_en = 1'b1;
        #1;
        check_bit("ce_on_b_gnt", bus1.o_b_gnt, 1'b1);
        check("ce_on_wdata", bus1.o_write_data, 32'hA5A5_A5A5);
        @(negedge clk);
        drive1(1'b1, 1'b1, 32'h64, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("b2b_b_gnt", bus1.o_b_gnt, 1'b1);
        check("b2b_waddr", bus1.o_write_addr, 32'h64);
        @(negedge clk);
        drive1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("b2b_write_count", 32'(writes1), 32'd3);

        // ---- 3: core read of 0x200 with RD_LAT=3 ----
        @(negedge clk);
        booted = 1'b1;
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0);
        #1;
        check_bit("t3_c0_c_gnt", bus3.o_c_gnt, 1'b1);
        check_bit("t3_c0_rd", bus3.o_read_req, 1'b1);
        check("t3_c0_raddr", bus3.o_read_addr, 32'h200);
        @(negedge clk);
        drive3(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("t3_c1_busy", bus3.o_busy, 1'b1);
        check_bit("t3_c1_b_gnt", bus3.o_b_gnt, 1'b0);
        check_bit("t3_c1_c_rvalid", bus3.o_c_rvalid, 1'b0);
        @(negedge clk); #1;
        check_bit("t3_c2_busy", bus3.o_busy, 1'b1);
        check_bit("t3_c2_b_gnt", bus3.o_b_gnt, 1'b0);
        check_bit("t3_c2_c_rvalid", bus3.o_c_rvalid, 1'b0);
        @(negedge clk); #1;
        check_bit("t3_c3_busy", bus3.o_busy, 1'b1);
        check_bit("t3_c3_c_rvalid", bus3.o_c_rvalid, 1'b1);
        check("t3_c3_c_rdata", bus3.o_c_rdata, 32'h1234_5678);
        check_bit("t3_c3_b_gnt", bus3.o_b_gnt, 1'b0);
        @(negedge clk); #1;
        check_bit("t3_c4_b_gnt", bus3.o_b_gnt, 1'b1);
        check_bit("t3_c4_busy", bus3.o_busy, 1'b0);
        check_bit("t3_c4_c_rvalid", bus3.o_c_rvalid, 1'b0);
        check("t3_c4_raddr", bus3.o_read_addr, 32'h40);

        // ---- 5: clk_en=0 for 5 cycles mid-RWAIT delays rvalid by 5 ----
        @(negedge clk);
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("t5_c5_busy", bus3.o_busy, 1'b1);
        check_bit("t5_c5_b_rvalid", bus3.o_b_rvalid, 1'b0);
        @(negedge clk);
        clk_en = 1'b0;
        #1;
        check_bit("t5_frz_busy", bus3.o_busy, 1'b1);
        check_bit("t5_frz_b_rvalid", bus3.o_b_rvalid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check_bit("t5_frz_loop_b_rvalid", bus3.o_b_rvalid, 1'b0);
        end
        @(negedge clk);
        clk_en = 1'b1;
        #1;
        check_bit("t5_c11_b_rvalid", bus3.o_b_rvalid, 1'b0);
        @(negedge clk); #1;
        check_bit("t5_c12_b_rvalid", bus3.o_b_rvalid, 1'b1);
        check("t5_c12_b_rdata", bus3.o_b_rdata, 32'h0040_5AA5);
        @(negedge clk); #1;
        check_bit("t5_c13_b_rvalid", bus3.o_b_rvalid, 1'b0);
        check("t5_c13_c_hold", bus3.o_c_rdata, 32'h1234_5678);

        // ---- 6: async reset during RWAIT ----
        @(negedge clk);
        drive3(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("t6_c0_b_gnt", bus3.o_b_gnt, 1'b1);
        @(negedge clk);
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_bit("t6_c1_busy", bus3.o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("t6_rst_busy", bus3.o_busy, 1'b0);
        check_bit("t6_rst_b_rvalid", bus3.o_b_rvalid, 1'b0);
        check("t6_rst_b_rdata", bus3.o_b_rdata, 32'h0);
        @(negedge clk); #1;
        check_bit("t6_hold_b_rvalid", bus3.o_b_rvalid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_bit("t6_rel_b_rvalid", bus3.o_b_rvalid, 1'b0);
        check_bit("t6_rel_busy", bus3.o_busy, 1'b0);
        @(negedge clk); #1;
        check_bit("t6_rel2_b_rvalid", bus3.o_b_rvalid, 1'b0);
        @(negedge clk);
        drive3(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b0, 32'h90, 32'h0);
        #1;
        check_bit("t6_tie_b_gnt", bus3.o_b_gnt, 1'b1);
        check_bit("t6_tie_c_gnt", bus3.o_c_gnt, 1'b0);
        check("t6_tie_raddr", bus3.o_read_addr, 32'h80);
        @(negedge clk);
        drive3(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk); #1;
        check_bit("t6_post_b_rvalid", bus3.o_b_rvalid, 1'b1);
        check("t6_post_b_rdata", bus3.o_b_rdata, 32'h0080_5AA5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
